exec_sequencer: RTL and testbench
=================================

// Module: exec_sequencer
// PURPOSE
//  Multi-cycle execute controller between instruction decode and the ALU/regfile/data memory.
//  Accepts one 32-bit instruction via valid/ready and decodes opcode [31:26].
//  Drives regfile reads, ALU start/op and data-memory access. Waits for multi-cycle ALU ops (MUL).
//  Sequences up to two write-backs through the single regfile write port.
// PARAMETERS
//  DATA_W       16  datapath/register width
//  REG_AW       5   register address width (fields Rdst2[25:21] Rdst1[20:16] Rsrc2[9:5]/[4:0] Rsrc1[4:0])
//  DADDR_W      8   data memory address width (LD addr [7:0]; ST addr [25:18])
//  ALU_TIMEOUT  64  max cycles waiting for alu_done (used only with EXEC_TIMEOUT_EN)
// PORTS
//  clk          in   1        single clock; all state on rising edge
//  rst          in   1        asynchronous, active-high reset
//  instr_valid  in   1        instruction offered
//  instr_ready  out  1        high only in IDLE; transfer on valid&&ready
//  instr        in   32       instruction word
//  rf_ra1/ra2   out  REG_AW   regfile read addrs (combinational read, data same cycle)
//  rf_rd1/rd2   in   DATA_W   regfile read data
//  rf_we        out  1        regfile write strobe
//  rf_wa/rf_wd  out  REG_AW/DATA_W  write address/data
//  alu_op       out  4        ALU function: opcode-4, valid while alu_start high
//  alu_a/alu_b  out  DATA_W   operands (Rsrc1, Rsrc2), held stable from EXEC until done
//  alu_start    out  1        one-cycle start pulse
//  alu_done     in   1        result valid; may be high in the same cycle as alu_start
//  alu_lo/hi    in   DATA_W   result low word / high word (carry, borrow, MUL upper)
//  dmem_addr    out  DADDR_W  data memory address
//  dmem_re/we   out  1        read/write strobes; read data valid next cycle
//  dmem_wdata   out  DATA_W   store data
//  dmem_rdata   in   DATA_W   load data
//  illegal_op   out  1        one-cycle pulse: opcode > 6'b010001 (or timeout)
// BEHAVIOUR
//  Reset: state IDLE; instr_ready=1 after deassert; all strobes, illegal_op 0; addr/data outputs 0.
//  Reset mid-op aborts: no write/store issued after rst asserts.
//  IDLE: on valid&&ready latch instr into IR and branch on opcode:
//   000000 LDI -> WB1: Rdst2<=imm[15:0].
//   000001 MOV -> READ -> WB1: Rdst2<=Rsrc2.
//   000010 LD  -> MEM_RD (re=1) -> WB1: Rdst2<=dmem_rdata.
//   000011 ST  -> READ -> MEM_ST: we=1, wdata=Rsrc2.
//   000100..010001 ALU -> READ -> EXEC -> [WAIT] -> WB1 [-> WB2].
//   other -> ILL: illegal_op=1 for 1 cycle; no side effects.
//  READ: ra1=Rsrc1, ra2=Rsrc2; operands latched at end of cycle.
//  EXEC: alu_start=1 for one cycle. alu_done same cycle -> capture lo/hi -> WB1, else WAIT.
//  WAIT: hold operands/op until alu_done, then capture lo/hi -> WB1.
//  Two-result ops ADD(000100), SUB(000101), MUL(000110):
//   WB1 writes Rdst1<=lo; WB2 writes Rdst2<=hi. If Rdst1==Rdst2 the register ends with hi.
//  All other ALU ops: WB1 only, Rdst1<=lo.
//  Latency, accept to ready: LDI 2; MOV/LD/ST 3; 1-word ALU 4; 2-word ALU 5 (+wait cycles).
//  rf_we asserted exactly one cycle per WB state. At most one write per cycle.
// CONFIGURATION
//  EXEC_TIMEOUT_EN defined:
//   WAIT counts cycles; ALU_TIMEOUT cycles without alu_done -> illegal_op pulse, IDLE, no write-back.
//  EXEC_TIMEOUT_EN undefined: WAIT indefinitely; no counter logic.
// STRUCTURE
//  exec_pkg: opcode localparams (OP_LDI..OP_0x11), state encoding, two-result-op predicate.
//  Sub-module exec_timeout_ctr: load/count/expire counter, instantiated only under EXEC_TIMEOUT_EN.
//  FSM, IR and operand/result registers live in exec_sequencer.
// TESTING
//  LDI R3,#0xBEEF -> one rf_we: wa=3, wd=0xBEEF, 2 cycles after accept; ready back.
//  ADD R2,R1 <- R4=0xFFFF,R5=0x0001 -> WB1 R1=0x0000, next cycle WB2 R2=0x0001.
//  MUL with alu_done 7 cycles after start -> alu_a/b stable throughout; lo then hi written.
//  ST [0x12]<-R6=0x00A5 -> dmem_we 1 cycle, addr 0x12, wdata 0x00A5; rf_we never high.
//  Opcode 6'b111111 -> illegal_op pulse, no rf_we/dmem_we; rst mid-WAIT -> IDLE, no write.
//  EXEC_TIMEOUT_EN, ALU_TIMEOUT=8, alu_done never -> illegal_op 8 cycles into WAIT.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared opcode map, FSM encoding and decoded-instruction view for the execute sequencer.
package exec_pkg;

  localparam logic [5:0] OP_LDI  = 6'h00;
  localparam logic [5:0] OP_MOV  = 6'h01;
  localparam logic [5:0] OP_LD   = 6'h02;
  localparam logic [5:0] OP_ST   = 6'h03;
  localparam logic [5:0] OP_ADD  = 6'h04;
  localparam logic [5:0] OP_SUB  = 6'h05;
  localparam logic [5:0] OP_MUL  = 6'h06;
  localparam logic [5:0] OP_0x11 = 6'h11;

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_MEM_RD, S_MEM_ST, S_EXEC, S_WAIT, S_WB1, S_WB2, S_ILL
  } state_t;

  // Register-form field layout; LDI/LD/ST reuse the low bits as imm/address.
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rdst2;
    logic [4:0] rdst1;
    logic [5:0] rsv;
    logic [4:0] rsrc2;
    logic [4:0] rsrc1;
  } instr_t;

  function automatic logic is_alu(input logic [5:0] op);
    return (op >= OP_ADD) && (op <= OP_0x11);
  endfunction

  function automatic logic is_two_result(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/exec_timeout_ctr.sv
// WAIT-state watchdog for the execute sequencer; only built when EXEC_TIMEOUT_EN is defined.
module exec_timeout_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // expire is raised during the LIMIT-th enabled cycle after load
  assign expire = en && (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= '0;
    else if (en && !expire) cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute controller: decode, regfile read, ALU handshake, dmem access, up to two write-backs.
// Define EXEC_TIMEOUT_EN to bound the ALU wait with an ALU_TIMEOUT-cycle watchdog.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 5,
  parameter int DADDR_W     = 8,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  output logic [REG_AW-1:0]  rf_ra1,
  output logic [REG_AW-1:0]  rf_ra2,
  input  logic [DATA_W-1:0]  rf_rd1,
  input  logic [DATA_W-1:0]  rf_rd2,
  output logic               rf_we,
  output logic [REG_AW-1:0]  rf_wa,
  output logic [DATA_W-1:0]  rf_wd,
  output logic [3:0]         alu_op,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic               alu_start,
  input  logic               alu_done,
  input  logic [DATA_W-1:0]  alu_lo,
  input  logic [DATA_W-1:0]  alu_hi,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic               dmem_re,
  output logic               dmem_we,
  output logic [DATA_W-1:0]  dmem_wdata,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic               illegal_op
);

  state_t            state, nxt;
  logic [31:0]       ir;
  instr_t            irf, dec;
  logic [DATA_W-1:0] opa, opb, res_lo, res_hi;
  logic              tmo_expire;

  assign irf = ir;
  assign dec = instr;

`ifdef EXEC_TIMEOUT_EN
  exec_timeout_ctr #(.LIMIT(ALU_TIMEOUT)) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .load   (state == S_EXEC),
    .en     (state == S_WAIT),
    .expire (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  // Operands stay frozen after READ, so alu_a/alu_b are stable through EXEC/WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir     <= '0;
      opa    <= '0;
      opb    <= '0;
      res_lo <= '0;
      res_hi <= '0;
    end else begin
      if (state == S_IDLE && instr_valid) ir <= instr;
      if (state == S_READ) begin
        opa <= rf_rd1;
        opb <= rf_rd2;
      end
      if ((state == S_EXEC || state == S_WAIT) && alu_done) begin
        res_lo <= alu_lo;
        res_hi <= alu_hi;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (instr_valid) begin
        if (dec.op == OP_LDI)     nxt = S_WB1;
        else if (dec.op == OP_LD) nxt = S_MEM_RD;
        else if (dec.op == OP_MOV || dec.op == OP_ST || is_alu(dec.op)) nxt = S_READ;
        else                      nxt = S_ILL;
      end
      S_READ:   nxt = (irf.op == OP_ST) ? S_MEM_ST : (irf.op == OP_MOV) ? S_WB1 : S_EXEC;
      S_MEM_RD: nxt = S_WB1;
      S_MEM_ST: nxt = S_IDLE;
      S_EXEC:   nxt = alu_done ? S_WB1 : S_WAIT;
      S_WAIT:   nxt = alu_done ? S_WB1 : (tmo_expire ? S_IDLE : S_WAIT);
      S_WB1:    nxt = is_two_result(irf.op) ? S_WB2 : S_IDLE;
      S_WB2:    nxt = S_IDLE;
      S_ILL:    nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    instr_ready = (state == S_IDLE);
    rf_ra1      = '0;
    rf_ra2      = '0;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    alu_op      = '0;
    alu_start   = 1'b0;
    dmem_addr   = '0;
    dmem_re     = 1'b0;
    dmem_we     = 1'b0;
    dmem_wdata  = '0;
    illegal_op  = 1'b0;
    alu_a       = opa;
    alu_b       = opb;
    case (state)
      S_READ: begin
        rf_ra1 = REG_AW'(irf.rsrc1);
        rf_ra2 = REG_AW'(irf.rsrc2);
      end
      S_MEM_RD: begin
        dmem_re   = 1'b1;
        dmem_addr = DADDR_W'(ir[7:0]);
      end
      S_MEM_ST: begin
        dmem_we    = 1'b1;
        dmem_addr  = DADDR_W'(ir[25:18]);
        dmem_wdata = opb;
      end
      S_EXEC: begin
        alu_start = 1'b1;
        alu_op    = 4'(irf.op - OP_ADD);
      end
      S_WAIT: begin
        alu_op     = 4'(irf.op - OP_ADD);
        illegal_op = tmo_expire && !alu_done;
      end
      S_WB1: begin
        rf_we = 1'b1;
        case (irf.op)
          OP_LDI: begin rf_wa = REG_AW'(irf.rdst2); rf_wd = DATA_W'(ir[15:0]); end
          OP_MOV: begin rf_wa = REG_AW'(irf.rdst2); rf_wd = opb;               end
          OP_LD:  begin rf_wa = REG_AW'(irf.rdst2); rf_wd = dmem_rdata;        end
          default: begin rf_wa = REG_AW'(irf.rdst1); rf_wd = res_lo;           end
        endcase
      end
      S_WB2: begin
        rf_we = 1'b1;
        rf_wa = REG_AW'(irf.rdst2);
        rf_wd = res_hi;
      end
      S_ILL:   illegal_op = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// Scoreboard bench for exec_sequencer: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_exec_sequencer;
  localparam int DATA_W = 16, REG_AW = 5, DADDR_W = 8, ALU_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [31:0] instr = '0;
  logic [REG_AW-1:0] rf_ra1, rf_ra2, rf_wa;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_wd;
  logic rf_we;
  logic [3:0] alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_lo, alu_hi;
  logic alu_start, alu_done;
  logic [DADDR_W-1:0] dmem_addr;
  logic dmem_re, dmem_we;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic illegal_op;

  exec_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW), .DADDR_W(DADDR_W), .ALU_TIMEOUT(ALU_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_start(alu_start), .alu_done(alu_done),
    .alu_lo(alu_lo), .alu_hi(alu_hi),
    .dmem_addr(dmem_addr), .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .illegal_op(illegal_op));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Regfile model with fixed source values, refreshed on reset
  logic [DATA_W-1:0] rf [32];
  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
      rf[4] <= 16'hFFFF; rf[5] <= 16'h0001; rf[6] <= 16'h00A5;
      rf[7] <= 16'h1234; rf[8] <= 16'h0003; rf[9] <= 16'h0005;
    end else if (rf_we) rf[rf_wa] <= rf_wd;
  end

  // Data memory returns 0xC300|addr one cycle after a read strobe
  always @(posedge clk) dmem_rdata <= dmem_re ? (16'hC300 | 16'(dmem_addr)) : 16'h0000;

  // ALU model with programmable done latency
  int alu_delay = 0;
  bit alu_never = 1'b0;
  logic alu_busy;
  int alu_cnt;
  logic [31:0] alu_w;
  always @(posedge clk or posedge rst) begin
    if (rst) begin alu_busy <= 1'b0; alu_cnt <= 0; end
    else if (alu_start && !alu_done) begin alu_busy <= 1'b1; alu_cnt <= 1; end
    else if (alu_busy) begin
      if (alu_done) alu_busy <= 1'b0;
      else          alu_cnt <= alu_cnt + 1;
    end
  end
  assign alu_done = !alu_never && ((alu_start && alu_delay == 0) || (alu_busy && alu_cnt == alu_delay));
  always_comb begin
    alu_w = '0;
    case (alu_op)
      4'd0:    alu_w = 32'(alu_a) + 32'(alu_b);
      4'd1:    alu_w = {15'd0, alu_a < alu_b, alu_a - alu_b};
      4'd2:    alu_w = 32'(alu_a) * 32'(alu_b);
      4'd3:    alu_w = {16'd0, alu_a & alu_b};
      default: alu_w = {16'd0, alu_a ^ alu_b};
    endcase
  end
  assign alu_lo = alu_w[15:0];
  assign alu_hi = alu_w[31:16];

  // kind: 0 rf write, 1 store, 2 illegal, 3 ready return, 4 post-reset state; cyc<0 means any cycle
  typedef struct { string name; int kind; int addr; int data; int cyc; } ev_t;
  ev_t expq[$];
  int n_cmp = 0, n_bad = 0;
  int acc = 0;
  bit fin = 1'b0;

  task automatic check_ev(input int kind, input int addr, input int data);
    ev_t e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h cyc=%0d, want none", kind, addr, data, cyc);
      return;
    end
    e = expq.pop_front();
    if (e.kind != kind || e.addr != addr || e.data != data || (e.cyc >= 0 && e.cyc != cyc)) begin
      n_bad++;
      $display("FAIL %s: got kind=%0d addr=%0h data=%0h cyc=%0d, want kind=%0d addr=%0h data=%0h cyc=%0d",
               e.name, kind, addr, data, cyc, e.kind, e.addr, e.data, e.cyc);
    end
  endtask

  logic rst_q = 1'b1, rdy_q = 1'b1;
  logic [DATA_W-1:0] sa, sb;
  logic [3:0] so;
  always @(negedge clk) begin
    if (rst) begin
      rst_q <= 1'b1;
      rdy_q <= 1'b1;
    end else begin
      if (rst_q)
        check_ev(4, int'(|{rf_ra1, rf_ra2, rf_wa, rf_wd, alu_op, alu_a, alu_b, dmem_addr, dmem_wdata}),
                 int'({alu_start, illegal_op, dmem_re, dmem_we, rf_we, instr_ready}));
      if (rf_we)      check_ev(0, int'(rf_wa), int'(rf_wd));
      if (dmem_we)    check_ev(1, int'(dmem_addr), int'(dmem_wdata));
      if (illegal_op) check_ev(2, 0, 0);
      if (instr_ready && !rdy_q) check_ev(3, 0, 0);
      if (alu_busy) begin
        n_cmp++;
        if (alu_a !== sa || alu_b !== sb || alu_op !== so) begin
          n_bad++;
          $display("FAIL alu_hold: got a=%0h b=%0h op=%0h, want a=%0h b=%0h op=%0h", alu_a, alu_b, alu_op, sa, sb, so);
        end
      end
      if (alu_start) begin sa <= alu_a; sb <= alu_b; so <= alu_op; end
      rst_q <= 1'b0;
      rdy_q <= instr_ready;
      if (fin) begin
        n_cmp++;
        if (expq.size() != 0) begin
          n_bad++;
          $display("FAIL missing_events: got %0d outstanding, want 0 (next %s)", expq.size(), expq[0].name);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd2, input logic [4:0] rd1,
                                      input logic [4:0] rs2, input logic [4:0] rs1);
    return {op, rd2, rd1, 6'd0, rs2, rs1};
  endfunction

  task automatic push(input string name, input int kind, input int addr, input int data, input int off);
    expq.push_back('{name, kind, addr, data, (off < 0) ? -1 : acc + off});
  endtask

  task automatic issue(input logic [31:0] w);
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    acc = cyc;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (instr_ready) return;
    end
    $display("FAIL ready_timeout: got instr_ready=0 after 100 cycles, want 1");
    $fatal(1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    push("reset_state", 4, 0, 1, -1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    do_reset();
    repeat (2) @(negedge clk);

    issue({6'h00, 5'd3, 5'd0, 16'hBEEF});
    push("ldi_wb", 0, 3, 'hBEEF, 1); push("ldi_ready", 3, 0, 0, 2);
    wait_ready();

    issue(enc(6'h01, 5'd10, 5'd0, 5'd7, 5'd0));
    push("mov_wb", 0, 10, 'h1234, 2); push("mov_ready", 3, 0, 0, 3);
    wait_ready();

    issue({6'h02, 5'd11, 13'd0, 8'h34});
    push("ld_wb", 0, 11, 'hC334, 2); push("ld_ready", 3, 0, 0, 3);
    wait_ready();

    issue({6'h03, 8'h12, 8'd0, 5'd6, 5'd0});
    push("st_write", 1, 'h12, 'h00A5, 2); push("st_ready", 3, 0, 0, 3);
    wait_ready();

    alu_delay = 0;
    issue(enc(6'h04, 5'd2, 5'd1, 5'd5, 5'd4));
    push("add_wb1", 0, 1, 'h0000, 3); push("add_wb2", 0, 2, 'h0001, 4); push("add_ready", 3, 0, 0, 5);
    wait_ready();

    alu_delay = 2;
    issue(enc(6'h05, 5'd13, 5'd12, 5'd8, 5'd9));
    push("sub_wb1", 0, 12, 'h0002, 5); push("sub_wb2", 0, 13, 'h0000, 6); push("sub_ready", 3, 0, 0, 7);
    wait_ready();

    alu_delay = 7;
    issue(enc(6'h06, 5'd15, 5'd14, 5'd6, 5'd4));
    push("mul_wb1", 0, 14, 'hFF5B, 10); push("mul_wb2", 0, 15, 'h00A4, 11); push("mul_ready", 3, 0, 0, 12);
    wait_ready();

    alu_delay = 0;
    issue(enc(6'h07, 5'd17, 5'd16, 5'd9, 5'd7));
    push("and_wb1", 0, 16, 'h0004, 3); push("and_ready", 3, 0, 0, 4);
    wait_ready();

    issue(enc(6'h04, 5'd18, 5'd18, 5'd5, 5'd4));
    push("samereg_wb1", 0, 18, 'h0000, 3); push("samereg_wb2", 0, 18, 'h0001, 4);
    push("samereg_ready", 3, 0, 0, 5);
    wait_ready();

    alu_delay = 1;
    issue(enc(6'h11, 5'd20, 5'd19, 5'd9, 5'd7));
    push("op11_wb1", 0, 19, 'h1231, 4); push("op11_ready", 3, 0, 0, 5);
    wait_ready();

    issue(enc(6'h12, 5'd1, 5'd1, 5'd4, 5'd5));
    push("op12_illegal", 2, 0, 0, 1); push("op12_ready", 3, 0, 0, 2);
    wait_ready();

    issue(enc(6'h3F, 5'd2, 5'd2, 5'd4, 5'd5));
    push("op3f_illegal", 2, 0, 0, 1); push("op3f_ready", 3, 0, 0, 2);
    wait_ready();

    // Reset while parked in WAIT: nothing may be written afterwards
    alu_never = 1'b1;
    issue(enc(6'h06, 5'd21, 5'd22, 5'd6, 5'd4));
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 alu_never = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);

    alu_delay = 0;
    issue({6'h00, 5'd23, 5'd0, 16'h5A5A});
    push("ldi_after_rst", 0, 23, 'h5A5A, 1); push("ldi_after_rst_ready", 3, 0, 0, 2);
    wait_ready();

`ifdef EXEC_TIMEOUT_EN
    alu_never = 1'b1;
    issue(enc(6'h06, 5'd24, 5'd25, 5'd6, 5'd4));
    push("timeout_illegal", 2, 0, 0, 10); push("timeout_ready", 3, 0, 0, 11);
    wait_ready();
`endif

    repeat (3) @(negedge clk);
    fin = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL summary_not_reached: got no finish, want finish");
    $fatal(1);
  end

endmodule
